// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data streams.
// Weighted round-robin same-cycle grant, one-cycle response routing, data kill.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 64,
  parameter int BE_WIDTH    = DATA_WIDTH / 8,
  parameter int DATA_WEIGHT = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic                  data_kill_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [BE_WIDTH-1:0]   mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CW = $clog2(DATA_WEIGHT + 1);

  typedef enum logic {
    SIDE_INSTR = 1'b0,
    SIDE_DATA  = 1'b1
  } side_e;

  side_e         last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          resp_vld_q;
  side_e         resp_own_q;
  logic          resp_we_q;
  logic          instr_gnt, data_gnt;

  // cnt_q==0 with last_q==data only occurs straight out of reset, so instr wins that tie
  always_comb begin
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    last_d    = last_q;
    cnt_d     = cnt_q;
    if (!rst_i) begin
      if (instr_req_i && data_req_i) begin
        if (last_q == SIDE_INSTR ||
            (cnt_q != '0 && cnt_q < CW'(DATA_WEIGHT))) begin
          data_gnt = 1'b1;
        end else begin
          instr_gnt = 1'b1;
        end
      end else begin
        instr_gnt = instr_req_i;
        data_gnt  = data_req_i;
      end
    end
    if (data_gnt) begin
      last_d = SIDE_DATA;
      if (!instr_req_i) begin
        cnt_d = CW'(1);
      end else if (cnt_q < CW'(DATA_WEIGHT)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (instr_gnt) begin
      last_d = SIDE_INSTR;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q     <= SIDE_DATA;
      cnt_q      <= '0;
      resp_vld_q <= 1'b0;
      resp_own_q <= SIDE_INSTR;
      resp_we_q  <= 1'b0;
    end else begin
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      resp_vld_q <= instr_gnt | data_gnt;
      resp_own_q <= data_gnt ? SIDE_DATA : SIDE_INSTR;
      resp_we_q  <= data_gnt & data_we_i;
    end
  end

  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;

  assign mem_req_o   = instr_gnt | data_gnt;
  assign mem_we_o    = data_gnt & data_we_i;
  assign mem_be_o    = data_gnt ? data_be_i : (instr_gnt ? '1 : '0);
  assign mem_addr_o  = data_gnt ? data_addr_i : (instr_gnt ? instr_addr_i : '0);
  assign mem_wdata_o = data_gnt ? data_wdata_i : '0;

  // A killed data response is only suppressed here; the RAM write already happened
  assign instr_rvalid_o = resp_vld_q && (resp_own_q == SIDE_INSTR);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rvalid_o  = resp_vld_q && (resp_own_q == SIDE_DATA) && !data_kill_i;
  assign data_rdata_o   = (data_rvalid_o && !resp_we_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a behavioural model.
module tb_mem_port_arbiter;
  localparam int AW = 24;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ireq, dreq, dwe, kill;
  logic [AW-1:0] iaddr, daddr;
  logic [BW-1:0] dbe;
  logic [DW-1:0] dwdata, mrdata;
  logic          igno, irv, dgno, drv, mreq, mwe;
  logic [DW-1:0] ird, drd, mwdata;
  logic [BW-1:0] mbe;
  logic [AW-1:0] maddr;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .DATA_WEIGHT(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(igno),
    .instr_rvalid_o(irv), .instr_rdata_o(ird),
    .data_req_i(dreq), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(daddr),
    .data_wdata_i(dwdata), .data_kill_i(kill), .data_gnt_o(dgno),
    .data_rvalid_o(drv), .data_rdata_o(drd),
    .mem_req_o(mreq), .mem_we_o(mwe), .mem_be_o(mbe), .mem_addr_o(maddr),
    .mem_wdata_o(mwdata), .mem_rdata_i(mrdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: whether the last grant went to data, and how many data grants in a row
  // it has had; m_run==W after reset means instr is owed the first tie.
  bit m_prev_data;
  int m_run;
  bit p_vld, p_data, p_we;
  bit obs_ig, obs_dg, obs_mwe, obs_iv, obs_dv;
  logic [BW-1:0] obs_mbe;
  logic [DW-1:0] obs_ir, obs_dr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_data = 1'b1;
    m_run       = W;
    p_vld       = 1'b0;
    p_data      = 1'b0;
    p_we        = 1'b0;
  endtask

  task automatic begin_cycle();
    #1;
    rst = 1'b0; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; kill = 1'b0;
    iaddr = '0; daddr = '0; dbe = '0; dwdata = '0;
    mrdata = {$urandom, $urandom};
  endtask

  task automatic check_cycle();
    bit ig, dg, e_iv, e_dv;
    logic [DW-1:0] e_ir, e_dr;
    #3;
    if (rst) model_reset();
    if (rst) begin
      ig = 1'b0; dg = 1'b0;
    end else if (ireq && dreq) begin
      dg = !m_prev_data || (m_run < W);
      ig = !dg;
    end else begin
      ig = ireq; dg = dreq;
    end
    e_iv = p_vld && !p_data;
    e_dv = p_vld && p_data && !kill;
    e_ir = e_iv ? mrdata : '0;
    e_dr = (e_dv && !p_we) ? mrdata : '0;
    chk("instr_gnt", igno, ig);
    chk("data_gnt", dgno, dg);
    chk("mem_req", mreq, ig | dg);
    chk("mem_we", mwe, dg && dwe);
    chk("mem_be", mbe, dg ? dbe : (ig ? 8'hFF : 8'h00));
    chk("mem_addr", maddr, dg ? daddr : (ig ? iaddr : '0));
    chk("mem_wdata", mwdata, dg ? dwdata : '0);
    chk("instr_rvalid", irv, e_iv);
    chk("instr_rdata", ird, e_ir);
    chk("data_rvalid", drv, e_dv);
    chk("data_rdata", drd, e_dr);
    obs_ig = igno; obs_dg = dgno; obs_mwe = mwe; obs_mbe = mbe;
    obs_iv = irv; obs_ir = ird; obs_dv = drv; obs_dr = drd;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (ig) begin
        m_prev_data = 1'b0; m_run = 0;
      end else if (dg) begin
        m_run = ireq ? ((m_run + 1 > W) ? W : m_run + 1) : 1;
        m_prev_data = 1'b1;
      end
      p_vld = ig | dg; p_data = dg; p_we = dg && dwe;
    end
  endtask

  initial begin
    logic [5:0] pat;
    model_reset();
    ireq = 1'b1; dreq = 1'b1; dwe = 1'b0; kill = 1'b0;
    iaddr = '0; daddr = '0; dbe = '0; dwdata = '0; mrdata = '0;
    @(posedge clk);
    @(posedge clk);

    // Reset with both requests high: everything quiet
    begin_cycle(); rst = 1'b1; ireq = 1'b1; dreq = 1'b1; check_cycle();
    chk("t1_rst_ignt", obs_ig, 1'b0);
    chk("t1_rst_dgnt", obs_dg, 1'b0);

    // Release with contention: I,D,D,I,D,D
    for (int i = 0; i < 6; i++) begin
      begin_cycle(); ireq = 1'b1; dreq = 1'b1;
      iaddr = AW'(i); daddr = AW'(24'h100 + i);
      check_cycle();
      pat[i] = obs_dg;
    end
    chk("t1_first_instr", {63'b0, pat[0]}, 64'd0);
    chk("t3_pattern", {58'b0, pat}, 64'b110110);

    // Instr only read
    begin_cycle(); iaddr = 24'h10; ireq = 1'b1; check_cycle();
    begin_cycle(); mrdata = 64'hDEAD_BEEF; check_cycle();
    chk("t2_irvalid", obs_iv, 1'b1);
    chk("t2_irdata", obs_ir, 64'hDEAD_BEEF);
    chk("t2_drvalid", obs_dv, 1'b0);

    // Data write
    begin_cycle(); dreq = 1'b1; dwe = 1'b1; dbe = 8'h0F; daddr = 24'h20;
    dwdata = 64'h1122_3344_5566_7788; check_cycle();
    chk("t4_mem_we", obs_mwe, 1'b1);
    chk("t4_mem_be", obs_mbe, 8'h0F);
    begin_cycle(); mrdata = 64'hFFFF_0000_FFFF; check_cycle();
    chk("t4_drvalid", obs_dv, 1'b1);
    chk("t4_drdata", obs_dr, 64'd0);

    // Killed read, then a normal one
    begin_cycle(); dreq = 1'b1; daddr = 24'h30; check_cycle();
    begin_cycle(); kill = 1'b1; check_cycle();
    chk("t5_killed", obs_dv, 1'b0);
    begin_cycle(); dreq = 1'b1; daddr = 24'h31; check_cycle();
    begin_cycle(); mrdata = 64'h0123_4567_89AB_CDEF; check_cycle();
    chk("t5_after_rv", obs_dv, 1'b1);
    chk("t5_after_rd", obs_dr, 64'h0123_4567_89AB_CDEF);

    // Reset right after a data grant drops its response
    begin_cycle(); dreq = 1'b1; daddr = 24'h40; check_cycle();
    chk("t6_granted", obs_dg, 1'b1);
    begin_cycle(); rst = 1'b1; check_cycle();
    chk("t6_rst_rv", obs_dv, 1'b0);
    begin_cycle(); check_cycle();
    chk("t6_post_rv", obs_dv, 1'b0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      begin_cycle();
      rst    = ($urandom_range(0, 79) == 0);
      ireq   = $urandom_range(0, 3) != 0;
      dreq   = $urandom_range(0, 3) != 0;
      dwe    = $urandom_range(0, 1) != 0;
      kill   = $urandom_range(0, 4) == 0;
      iaddr  = AW'($urandom);
      daddr  = AW'($urandom);
      dbe    = BW'($urandom);
      dwdata = {$urandom, $urandom};
      check_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
